// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder: detects key_code events, queues them in a FWFT FIFO and
// presents one-hot commands over valid/ready. Optional event holdoff: KEY_HOLDOFF_EN.
module key_cmd_decoder #(
  parameter int DEPTH          = 4,
  parameter int HOLDOFF_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 key_code,
  input  logic                       cmd_ready,
  output logic                       cmd_valid,
  output logic [1:0]                 cmd_code,
  output logic                       cmd_up,
  output logic                       cmd_left,
  output logic                       cmd_right,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF_CYCLES < 1) begin : g_bad_params
    $error("key_cmd_decoder: DEPTH must be a power of two >= 2 and HOLDOFF_CYCLES >= 1");
  end

  logic [1:0]  prev_code;
  logic [1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;

  logic key_event;
  logic holdoff_busy;
  logic eligible;
  logic pop;
  logic push;
  logic drop;
  logic full;

  assign key_event = (key_code != 2'b00) && (key_code != prev_code);
  assign eligible  = key_event && !holdoff_busy;
  assign full      = (count == FULL_COUNT);
  assign cmd_valid = (count != '0);
  assign pop       = cmd_valid && cmd_ready;
  // A full FIFO still accepts an event when the head leaves on the same edge.
  assign push      = eligible && (!full || pop);
  assign drop      = eligible && full && !pop;

`ifdef KEY_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [HW-1:0] holdoff_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdoff_cnt <= '0;
    end else if (push) begin
      holdoff_cnt <= HW'(HOLDOFF_CYCLES);
    end else if (holdoff_cnt != '0) begin
      holdoff_cnt <= holdoff_cnt - 1'b1;
    end
  end

  assign holdoff_busy = (holdoff_cnt != '0);
`else
  assign holdoff_busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_code <= 2'b00;
    end else begin
      prev_code <= key_code;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      overflow <= drop;
      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Storage is not reset, so the head is masked until an entry exists.
  always_comb begin
    cmd_code  = 2'b00;
    cmd_up    = 1'b0;
    cmd_left  = 1'b0;
    cmd_right = 1'b0;
    if (cmd_valid) begin
      cmd_code  = mem[rd_ptr];
      cmd_up    = (mem[rd_ptr] == 2'b11);
      cmd_left  = (mem[rd_ptr] == 2'b01);
      cmd_right = (mem[rd_ptr] == 2'b10);
    end
  end

  assign fill_level = count;

endmodule
